// File: rtl/exe_stage.sv
// Execute stage with EXE/MEM pipeline register.
// Single-cycle ALU plus an iterative shift-add multiplier that stalls upstream via exe_busy.
module exe_stage #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic             ewmem,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic [WIDTH-1:0] eqa,
  input  logic [WIDTH-1:0] eqb,
  input  logic [WIDTH-1:0] eSignExtend,
  input  logic [4:0]       etemp,
  output logic             exe_busy,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [WIDTH-1:0] malu,
  output logic [WIDTH-1:0] mqb,
  output logic [4:0]       mtemp
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(MUL_ITER) + 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] alu_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_mul_s;
  logic             busy_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;

  assign b_s      = ealuimm ? eSignExtend : eqb;
  assign shamt_s  = b_s[SHW-1:0];
  assign is_mul_s = (ealuc == OP_MUL);

  // Single-cycle ALU; MUL and unused opcodes yield zero here.
  always_comb begin
    alu_s = '0;
    case (ealuc)
      OP_ADD:  alu_s = eqa + b_s;
      OP_SUB:  alu_s = eqa - b_s;
      OP_AND:  alu_s = eqa & b_s;
      OP_OR:   alu_s = eqa | b_s;
      OP_XOR:  alu_s = eqa ^ b_s;
      OP_SLL:  alu_s = eqa << shamt_s;
      OP_SRL:  alu_s = eqa >> shamt_s;
      OP_SRA:  alu_s = $unsigned($signed(eqa) >>> shamt_s);
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(eqa) < $signed(b_s))};
      OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (eqa < b_s)};
      OP_LUI:  alu_s = b_s << 16;
      default: alu_s = '0;
    endcase
  end

  // Busy is held low in reset and whenever flush kills the instruction.
  always_comb begin
    busy_s = 1'b0;
    if (clrn && !flush) begin
      busy_s = (state_r == RUN) || ((state_r == IDLE) && is_mul_s);
    end else begin
      busy_s = 1'b0;
    end
  end

  assign exe_busy = busy_s;

  // Next-state logic for the multiplier sequencer.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_mul_s) state_s = RUN;
          else          state_s = IDLE;
        end
        RUN: begin
          if (cnt_r == CW'(MUL_ITER - 1)) state_s = DONE;
          else                            state_s = RUN;
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Shift-add datapath: operands are latched on entry, one partial product per RUN edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (flush) begin
      cnt_r    <= '0;
    end else if (state_r == IDLE && is_mul_s) begin
      mcand_r  <= eqa;
      mplier_r <= b_s;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (state_r == RUN) begin
      if (mplier_r[0]) acc_r <= acc_r + mcand_r;
      else             acc_r <= acc_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // EXE/MEM register: bubble on flush or stall, otherwise ALU or multiplier result.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      malu   <= '0;
      mqb    <= '0;
      mtemp  <= 5'd0;
    end else if (flush || busy_s) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      malu   <= '0;
      mqb    <= '0;
      mtemp  <= 5'd0;
    end else begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      malu   <= (state_r == DONE) ? acc_r : alu_s;
      mqb    <= eqb;
      mtemp  <= etemp;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic [31:0] eqa;
  logic [31:0] eqb;
  logic [31:0] eSignExtend;
  logic [4:0]  etemp;
  logic        exe_busy;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mqb;
  logic [4:0]  mtemp;

  int n_cmp = 0;
  int n_err = 0;

  exe_stage #(.WIDTH(32), .MUL_ITER(32)) dut (
    .clk(clk), .clrn(clrn), .flush(flush), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ealuc(ealuc), .ealuimm(ealuimm), .eqa(eqa), .eqb(eqb),
    .eSignExtend(eSignExtend), .etemp(etemp), .exe_busy(exe_busy),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .malu(malu), .mqb(mqb),
    .mtemp(mtemp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic imm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] se, input logic wr,
                        input logic [4:0] rd);
    ealuc = op; ealuimm = imm; eqa = a; eqb = b; eSignExtend = se;
    ewreg = wr; etemp = rd; ewmem = 1'b0; em2reg = 1'b0;
  endtask

  // Issue a MUL (inputs held) and walk it to completion within a cycle budget.
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input logic [4:0] rd);
    int  cyc;
    int  busy_cnt;
    int  bub_bad;
    bit  done;
    logic bsy;
    cyc = 0; busy_cnt = 0; bub_bad = 0; done = 1'b0;
    set_op(4'hB, 1'b0, a, b, 32'h0, 1'b1, rd);
    while (!done && cyc < 100) begin
      #1;
      bsy = exe_busy;
      if (bsy) busy_cnt++;
      step();
      cyc++;
      if (bsy) begin
        if (mwreg !== 1'b0 || malu !== 32'h0) bub_bad++;
      end else begin
        done = 1'b1;
      end
    end
    check_val({tag, "_cycles"}, 32'(cyc), 32'd34);
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check_val({tag, "_bubble"}, 32'(bub_bad), 32'd0);
    check_val({tag, "_malu"}, malu, prod);
    check_val({tag, "_mwreg"}, {31'd0, mwreg}, 32'd1);
    check_val({tag, "_mtemp"}, {27'd0, mtemp}, {27'd0, rd});
    set_op(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'h7, 1'b0, 32'h80000000, 32'h00000004, 32'h0, 32'hF8000000}; // SRA
    vecs[1] = '{4'h8, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000001}; // SLT
    vecs[2] = '{4'h9, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000}; // SLTU
    vecs[3] = '{4'hA, 1'b1, 32'h0, 32'h0, 32'h00001234, 32'h12340000};       // LUI
    vecs[4] = '{4'h6, 1'b0, 32'h80000000, 32'h00000004, 32'h0, 32'h08000000}; // SRL
    vecs[5] = '{4'h1, 1'b0, 32'h00000003, 32'h00000005, 32'h0, 32'hFFFFFFFE}; // SUB wrap
    vecs[6] = '{4'h4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0}; // XOR
    vecs[7] = '{4'h5, 1'b0, 32'h00000001, 32'h00000024, 32'h0, 32'h00000010}; // SLL uses b[4:0]
    vecs[8] = '{4'h2, 1'b1, 32'h12345678, 32'h0, 32'h0000FFFF, 32'h00005678}; // AND imm
    vecs[9] = '{4'hC, 1'b0, 32'h12345678, 32'h11111111, 32'h0, 32'h00000000}; // unused op

    clrn = 1'b0; flush = 1'b0;
    set_op(4'hB, 1'b0, 32'h7, 32'h6, 32'h0, 1'b1, 5'd9);
    #2;
    check_val("rst_busy", {31'd0, exe_busy}, 32'd0);
    check_val("rst_mwreg", {31'd0, mwreg}, 32'd0);
    check_val("rst_malu", malu, 32'd0);
    set_op(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    #10;
    clrn = 1'b1;
    step();

    // ADD with negative immediate
    set_op(4'h0, 1'b1, 32'd5, 32'h0, 32'hFFFFFFFD, 1'b1, 5'd7);
    #1;
    check_val("add_busy", {31'd0, exe_busy}, 32'd0);
    step();
    check_val("add_malu", malu, 32'd2);
    check_val("add_mwreg", {31'd0, mwreg}, 32'd1);
    check_val("add_mtemp", {27'd0, mtemp}, 32'd7);

    for (int i = 0; i < 10; i++) begin
      set_op(vecs[i].op, vecs[i].imm, vecs[i].a, vecs[i].b, vecs[i].se, 1'b1, 5'd1);
      #1;
      check_val($sformatf("alu%0d_busy", i), {31'd0, exe_busy}, 32'd0);
      step();
      check_val($sformatf("alu%0d_res", i), malu, vecs[i].res);
    end

    mul_run("mul_neg", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 5'd5);

    // MUL aborted by flush on the tenth RUN cycle
    set_op(4'hB, 1'b0, 32'd7, 32'd6, 32'h0, 1'b1, 5'd4);
    step();
    repeat (9) step();
    check_val("flush_prebusy", {31'd0, exe_busy}, 32'd1);
    flush = 1'b1;
    #1;
    check_val("flush_busy", {31'd0, exe_busy}, 32'd0);
    step();
    check_val("flush_mwreg", {31'd0, mwreg}, 32'd0);
    check_val("flush_malu", malu, 32'd0);
    flush = 1'b0;
    set_op(4'h0, 1'b0, 32'd10, 32'd20, 32'h0, 1'b1, 5'd3);
    #1;
    check_val("postflush_busy", {31'd0, exe_busy}, 32'd0);
    step();
    check_val("postflush_malu", malu, 32'd30);
    check_val("postflush_mwreg", {31'd0, mwreg}, 32'd1);

    // Async reset while a MUL is pending and m* still holds the ADD result
    set_op(4'hB, 1'b0, 32'd9, 32'd11, 32'h0, 1'b1, 5'd6);
    #1;
    check_val("rstmul_busy_pre", {31'd0, exe_busy}, 32'd1);
    #1;
    clrn = 1'b0;
    #1;
    check_val("rstmul_busy", {31'd0, exe_busy}, 32'd0);
    check_val("rstmul_malu", malu, 32'd0);
    check_val("rstmul_mwreg", {31'd0, mwreg}, 32'd0);
    check_val("rstmul_mtemp", {27'd0, mtemp}, 32'd0);
    #2;
    clrn = 1'b1;
    mul_run("mul_after_rst", 32'd9, 32'd11, 32'd99, 5'd6);

    // Store: address from immediate, data always eqb
    set_op(4'h0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h8, 1'b0, 5'd0);
    ewmem = 1'b1;
    step();
    check_val("st_malu", malu, 32'h108);
    check_val("st_mqb", mqb, 32'hDEADBEEF);
    check_val("st_mwmem", {31'd0, mwmem}, 32'd1);
    check_val("st_mwreg", {31'd0, mwreg}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
